id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand preparation for the 64-bit pipelined core.
//  - Captures decoded ID-stage fields on each clock.
//  - Resolves EX/MEM and MEM/WB forwarding and selects immediate vs register for operand 2.
//  - Generates the 4-bit ALU control, so its outputs drive the ALU's ctl/op1/op2 directly.
//  - Detects load-use hazards and requests a front-end stall.
// PARAMETERS
//  XLEN        64  datapath width
//  REG_AW      5   register-address width (x0 hardwired zero)
// PORTS
//  clk            in   1       rising-edge clock (single clock domain)
//  rst_n          in   1       asynchronous active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_rs1,id_rs2  in   REG_AW  source register addresses
//  id_rd          in   REG_AW  destination register
//  id_rs1_data    in   XLEN    register-file read data 1
//  id_rs2_data    in   XLEN    register-file read data 2
//  id_imm         in   XLEN    sign-extended immediate
//  id_aluop       in   2       00 mem / 01 branch / 10 R-type
//  id_funct       in   4       {instr[30], funct3}
//  id_alusrc      in   1       1 = op2 from immediate
//  id_ctrl        in   5       {regwrite, memread, memwrite, memtoreg, branch}
//  hold           in   1       external stall: freeze the register
//  flush          in   1       kill the instruction entering EX (taken branch)
//  exm_regwrite   in   1       EX/MEM writes a register
//  exm_rd         in   REG_AW  EX/MEM destination
//  exm_result     in   XLEN    EX/MEM ALU result
//  mwb_regwrite   in   1       MEM/WB writes a register
//  mwb_rd         in   REG_AW  MEM/WB destination
//  mwb_data       in   XLEN    MEM/WB write-back data
//  stall_req      out  1       load-use detected; front end must hold PC and IF/ID
//  ex_valid       out  1       EX slot holds a real instruction
//  alu_ctl        out  4       ALU operation
//  alu_op1        out  XLEN    ALU operand 1
//  alu_op2        out  XLEN    ALU operand 2
//  ex_store_data  out  XLEN    forwarded rs2, for stores
//  ex_rd          out  REG_AW  destination register, passed to EX/MEM
//  ex_ctrl        out  5       control bits, passed to EX/MEM
//  ex_illegal     out  1       unsupported R-type funct in EX
// BEHAVIOUR
//  - Reset (asynchronous): every register field = 0, so ex_valid=0, ex_ctrl=0, ex_rd=0, alu_ctl=0010.
//  - Register-load priority per clock:
//    1. flush: load a bubble (valid=0, ctrl=0).
//    2. hold: retain all fields.
//    3. stall_req: load a bubble.
//    4. otherwise: load the ID fields.
//  - Latency: 1 clock, ID fields to EX outputs.
//  - All EX outputs are combinational from the register and the forwarding inputs.
//  - stall_req = ex_valid & ex_ctrl.memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    Only the current contents of this register are checked; a load 2+ stages ahead is covered by forwarding.
//  - Forwarding, per source operand, in priority order:
//    1. EX/MEM when exm_regwrite & exm_rd!=0 & exm_rd==rs.
//    2. Else MEM/WB when mwb_regwrite & mwb_rd!=0 & mwb_rd==rs.
//    3. Else the registered read data.
//    Both matching: EX/MEM wins (youngest value). x0 is never forwarded.
//  - alu_op1 = fwd rs1.
//  - alu_op2 = alusrc ? imm : fwd rs2.
//  - ex_store_data = fwd rs2, regardless of alusrc.
//  - ALU control:
//    aluop 00 -> 0010 (add); aluop 01 -> 0110 (sub).
//    aluop 10 with funct 0000 -> add, 1000 -> sub, 0111 -> and (0000), 0110 -> or (0001).
//    Any other aluop 10 funct -> 1111 (ALU returns 0); ex_illegal=1 when ex_valid.
//    aluop 11 -> 0010, ex_illegal=0.
//  - Bubble (valid=0): ctrl=0 and illegal=0; no architectural side effect.
//  - Reset asserted mid-operation clears the in-flight instruction immediately; stall_req drops to 0.
// CONFIGURATION
//  EX_FORWARD_EN defined (default build):
//    forwarding and load-use stall_req as above.
//  EX_FORWARD_EN undefined:
//    operands come straight from registered read data; exm_*/mwb_* are ignored.
//    stall_req is tied to 0; hazard avoidance is the compiler's job (NOP insertion).
// STRUCTURE
//  - Shared package cpu_pkg:
//    ALU_ADD/SUB/AND/OR/NOP codes.
//    ALUOP_MEM/BR/R encodings.
//    ctrl-bundle bit indices; XLEN and REG_AW.
//  - Sub-module alu_control: aluop+funct -> alu_ctl, illegal. Purely combinational, reused by tests.
//  - Forwarding mux and hazard compare are inline.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> ex_valid=0, ex_ctrl=0, stall_req=0 immediately.
//  2. R-type add, no hazard:
//     rs1_data=5, rs2_data=7, funct 0000 -> next cycle alu_ctl=0010, op1=5, op2=7.
//  3. Double forward:
//     EX/MEM rd=3 result=0xAA and MEM/WB rd=3 data=0xBB, rs1=3 -> alu_op1=0xAA.
//     Same hazard with rd=0 -> no forward.
//  4. Load-use: EX holds ld x4, ID uses x4 -> stall_req=1; next cycle ex_valid=0.
//     With hold=1 instead, the register is unchanged.
//  5. Priority: flush=1 and hold=1 together -> bubble loaded.
//     Store with alusrc=1 -> op2=imm, ex_store_data=forwarded rs2.
//  6. Illegal funct 0011, aluop 10 -> alu_ctl=1111, ex_illegal=1.
//     Rebuild without EX_FORWARD_EN -> test 3 yields registered rs1_data.

Source files
------------

// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg                                                                  |
// | Shared constants and types for the 64-bit pipelined core.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 5;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // Bit positions inside the {regwrite, memread, memwrite, memtoreg, branch} bundle
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [1:0]        aluop;
    logic [3:0]        funct;
    logic              alusrc;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] wrd,
                                   input logic [REG_AW-1:0] rs);
    return we && (wrd != '0) && (wrd == rs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_control.sv
// +--------------------------------------------------------------------------+
// | alu_control                                                              |
// | Maps aluop/funct to the 4-bit ALU operation and flags unsupported funct. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_control
  import cpu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output logic [3:0] alu_ctl,
  output logic       illegal
);

  always_comb begin
    alu_ctl = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: alu_ctl = ALU_ADD;
      ALUOP_BR:  alu_ctl = ALU_SUB;
      ALUOP_R: begin
        case (funct)
          4'b0000: alu_ctl = ALU_ADD;
          4'b1000: alu_ctl = ALU_SUB;
          4'b0111: alu_ctl = ALU_AND;
          4'b0110: alu_ctl = ALU_OR;
          default: begin
            alu_ctl = ALU_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_operand_stage                                                      |
// | ID/EX register with forwarding, operand-2 select, ALU control and        |
// | load-use stall. Macro EX_FORWARD_EN enables forwarding and stall_req.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [1:0]        id_aluop,
  input  logic [3:0]        id_funct,
  input  logic              id_alusrc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              hold,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_regwrite,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  output logic              stall_req,
  output logic              ex_valid,
  output logic [3:0]        alu_ctl,
  output logic [XLEN-1:0]   alu_op1,
  output logic [XLEN-1:0]   alu_op2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_illegal
);

  idex_t           r_ex;
  idex_t           w_id;
  logic            w_stall;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_illegal;

  always_comb begin
    w_id          = '0;
    w_id.valid    = id_valid;
    w_id.rs1      = id_rs1;
    w_id.rs2      = id_rs2;
    w_id.rd       = id_rd;
    w_id.rs1_data = id_rs1_data;
    w_id.rs2_data = id_rs2_data;
    w_id.imm      = id_imm;
    w_id.aluop    = id_aluop;
    w_id.funct    = id_funct;
    w_id.alusrc   = id_alusrc;
    w_id.ctrl     = id_ctrl;
  end

  // A bubble clears every field, so a killed slot can never carry stale control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ex <= '0;
    else if (flush)   r_ex <= '0;
    else if (hold)    r_ex <= r_ex;
    else if (w_stall) r_ex <= '0;
    else              r_ex <= w_id;
  end

`ifdef EX_FORWARD_EN
  // EX/MEM is checked first so the youngest in-flight value wins
  always_comb begin
    w_fwd1 = r_ex.rs1_data;
    if (fwd_hit(exm_regwrite, exm_rd, r_ex.rs1))      w_fwd1 = exm_result;
    else if (fwd_hit(mwb_regwrite, mwb_rd, r_ex.rs1)) w_fwd1 = mwb_data;
    w_fwd2 = r_ex.rs2_data;
    if (fwd_hit(exm_regwrite, exm_rd, r_ex.rs2))      w_fwd2 = exm_result;
    else if (fwd_hit(mwb_regwrite, mwb_rd, r_ex.rs2)) w_fwd2 = mwb_data;
  end

  assign w_stall = r_ex.valid & r_ex.ctrl[CTRL_MEMREAD] & (r_ex.rd != '0) & id_valid &
                   ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2));
`else
  logic w_unused;

  assign w_fwd1   = r_ex.rs1_data;
  assign w_fwd2   = r_ex.rs2_data;
  assign w_stall  = 1'b0;
  assign w_unused = ^{exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_data,
                      r_ex.rs1, r_ex.rs2};
`endif

  alu_control u_alu_control (
    .aluop   (r_ex.aluop),
    .funct   (r_ex.funct),
    .alu_ctl (alu_ctl),
    .illegal (w_illegal)
  );

  assign stall_req     = w_stall;
  assign ex_valid      = r_ex.valid;
  assign alu_op1       = w_fwd1;
  assign alu_op2       = r_ex.alusrc ? r_ex.imm : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign ex_rd         = r_ex.rd;
  assign ex_ctrl       = r_ex.ctrl;
  assign ex_illegal    = r_ex.valid & w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// +--------------------------------------------------------------------------+
// | tb_id_ex_operand_stage                                                   |
// | Directed scoreboard bench for id_ex_operand_stage (either build option). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_operand_stage;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [1:0]  id_aluop;
  logic [3:0]  id_funct;
  logic        id_alusrc;
  logic [4:0]  id_ctrl;
  logic        hold, flush;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [63:0] exm_result, mwb_data;
  logic        stall_req, ex_valid, ex_illegal;
  logic [3:0]  alu_ctl;
  logic [63:0] alu_op1, alu_op2, ex_store_data;
  logic [4:0]  ex_rd, ex_ctrl;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    bit          full;
    logic        v;
    logic [3:0]  ctl;
    logic [63:0] op1, op2, sd;
    logic [4:0]  rd, ctrl;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc), .id_ctrl(id_ctrl),
    .hold(hold), .flush(flush), .exm_regwrite(exm_regwrite), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .stall_req(stall_req), .ex_valid(ex_valid), .alu_ctl(alu_ctl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic [1:0] aluop,
                          input logic [3:0] funct, input logic alusrc, input logic [4:0] ctrl);
    id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
    id_rs1_data = d1;  id_rs2_data = d2;  id_imm = imm;
    id_aluop = aluop;  id_funct = funct;  id_alusrc = alusrc;  id_ctrl = ctrl;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [63:0] er,
                         input logic mw, input logic [4:0] mrd, input logic [63:0] md);
    exm_regwrite = ew;  exm_rd = erd;  exm_result = er;
    mwb_regwrite = mw;  mwb_rd = mrd;  mwb_data = md;
  endtask

  task automatic push(input string tag, input bit full, input logic v, input logic [3:0] ctl,
                      input logic [63:0] op1, input logic [63:0] op2, input logic [63:0] sd,
                      input logic [4:0] rd, input logic [4:0] ctrl, input logic ill);
    exp_t e;
    e.tag = tag;  e.full = full;  e.v = v;  e.ctl = ctl;
    e.op1 = op1;  e.op2 = op2;  e.sd = sd;  e.rd = rd;  e.ctrl = ctrl;  e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic check_ex();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".valid"}, 64'(ex_valid), 64'(e.v));
    chk({e.tag, ".ctrl"}, 64'(ex_ctrl), 64'(e.ctrl));
    chk({e.tag, ".illegal"}, 64'(ex_illegal), 64'(e.ill));
    if (e.full) begin
      chk({e.tag, ".alu_ctl"}, 64'(alu_ctl), 64'(e.ctl));
      chk({e.tag, ".op1"}, alu_op1, e.op1);
      chk({e.tag, ".op2"}, alu_op2, e.op2);
      chk({e.tag, ".store"}, ex_store_data, e.sd);
      chk({e.tag, ".rd"}, 64'(ex_rd), 64'(e.rd));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [1:0] t_aluop[6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
    logic [3:0] t_funct[6] = '{4'b0011, 4'b0111, 4'b0110, 4'b0000, 4'b0101, 4'b1111};
    logic [3:0] t_ctl[6]   = '{4'b1111, 4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b1111};
    logic       t_ill[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;  hold = 1'b0;  flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 5'b00000);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset.valid", 64'(ex_valid), 64'd0);
    chk("reset.ctrl", 64'(ex_ctrl), 64'd0);
    chk("reset.rd", 64'(ex_rd), 64'd0);
    chk("reset.alu_ctl", 64'(alu_ctl), 64'h2);
    chk("reset.stall", 64'(stall_req), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // R-type add, no hazard
    drive_id(1, 1, 2, 5, 64'd5, 64'd7, 64'd0, 2'b10, 4'b0000, 0, 5'b10000);
    push("radd", 1, 1, 4'b0010, 64'd5, 64'd7, 64'd7, 5'd5, 5'b10000, 0);
    cycle();  check_ex();

    // Double forward on rs1, then MEM/WB only, then EX/MEM onto rs2
    drive_id(1, 3, 6, 7, 64'h11, 64'h22, 64'd0, 2'b10, 4'b1000, 0, 5'b10000);
    push("dfwd", 1, 1, 4'b0110, FWD ? 64'hAA : 64'h11, 64'h22, 64'h22, 5'd7, 5'b10000, 0);
    cycle();
    set_fwd(1, 3, 64'hAA, 1, 3, 64'hBB);
    #1;  check_ex();
    set_fwd(0, 3, 64'hAA, 1, 3, 64'hBB);
    #1;  chk("mwb_only.op1", alu_op1, FWD ? 64'hBB : 64'h11);
    set_fwd(1, 6, 64'hCC, 0, 0, 64'd0);
    #1;  chk("exm_rs2.op2", alu_op2, FWD ? 64'hCC : 64'h22);
    chk("exm_rs2.store", ex_store_data, FWD ? 64'hCC : 64'h22);

    // x0 is never forwarded
    drive_id(1, 0, 0, 7, 64'h33, 64'h44, 64'd0, 2'b10, 4'b0000, 0, 5'b10000);
    push("x0", 1, 1, 4'b0010, 64'h33, 64'h44, 64'h44, 5'd7, 5'b10000, 0);
    cycle();
    set_fwd(1, 0, 64'hAA, 1, 0, 64'hBB);
    #1;  check_ex();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load-use: ld x4 in EX, dependent add in ID
    drive_id(1, 1, 0, 4, 64'h100, 64'd0, 64'h10, 2'b00, 4'b0000, 1, 5'b11010);
    push("ld", 1, 1, 4'b0010, 64'h100, 64'h10, 64'd0, 5'd4, 5'b11010, 0);
    cycle();
    drive_id(1, 4, 2, 8, 64'h40, 64'h2, 64'd0, 2'b10, 4'b0000, 0, 5'b10000);
    #1;  check_ex();
    chk("loaduse.stall", 64'(stall_req), 64'(FWD));
    if (FWD) push("lu_bubble", 0, 0, 4'b0010, 64'd0, 64'd0, 64'd0, 5'd0, 5'b00000, 0);
    else     push("lu_add", 1, 1, 4'b0010, 64'h40, 64'h2, 64'h2, 5'd8, 5'b10000, 0);
    cycle();  check_ex();
    chk("after_bubble.stall", 64'(stall_req), 64'd0);
    push("lu_add2", 1, 1, 4'b0010, 64'h40, 64'h2, 64'h2, 5'd8, 5'b10000, 0);
    cycle();  check_ex();

    // Hold beats the load-use bubble: register unchanged
    drive_id(1, 1, 0, 4, 64'h100, 64'd0, 64'h10, 2'b00, 4'b0000, 1, 5'b11010);
    push("ld2", 1, 1, 4'b0010, 64'h100, 64'h10, 64'd0, 5'd4, 5'b11010, 0);
    cycle();
    drive_id(1, 4, 2, 8, 64'h40, 64'h2, 64'd0, 2'b10, 4'b0000, 0, 5'b10000);
    hold = 1'b1;
    #1;  check_ex();
    push("hold_ld", 1, 1, 4'b0010, 64'h100, 64'h10, 64'd0, 5'd4, 5'b11010, 0);
    cycle();  check_ex();
    chk("hold.stall", 64'(stall_req), 64'(FWD));

    // Flush together with hold loads a bubble
    flush = 1'b1;
    push("flush_hold", 0, 0, 4'b0010, 64'd0, 64'd0, 64'd0, 5'd0, 5'b00000, 0);
    cycle();  check_ex();
    flush = 1'b0;  hold = 1'b0;

    // Store: op2 = imm, store data = forwarded rs2
    drive_id(1, 1, 9, 0, 64'h200, 64'h55, 64'h8, 2'b00, 4'b0010, 1, 5'b00100);
    push("sw", 1, 1, 4'b0010, 64'h200, 64'h8, FWD ? 64'h77 : 64'h55, 5'd0, 5'b00100, 0);
    cycle();
    set_fwd(0, 0, 0, 1, 9, 64'h77);
    #1;  check_ex();
    set_fwd(0, 0, 0, 0, 0, 0);

    // ALU control table including illegal R-type funct
    for (int i = 0; i < 6; i++) begin
      drive_id(1, 1, 2, 3, 64'(i + 1), 64'h9, 64'd0, t_aluop[i], t_funct[i], 0, 5'b10000);
      push($sformatf("aluctl%0d", i), 1, 1, t_ctl[i], 64'(i + 1), 64'h9, 64'h9, 5'd3,
           5'b10000, t_ill[i]);
      cycle();  check_ex();
    end
    drive_id(0, 1, 2, 3, 64'd1, 64'd2, 64'd0, 2'b10, 4'b0011, 0, 5'b00000);
    push("inv_illegal", 0, 0, 4'b1111, 64'd0, 64'd0, 64'd0, 5'd0, 5'b00000, 0);
    cycle();  check_ex();

    // Asynchronous reset mid-cycle while a load-use stall is pending
    drive_id(1, 1, 0, 4, 64'h100, 64'd0, 64'h10, 2'b00, 4'b0000, 1, 5'b11010);
    push("ld3", 1, 1, 4'b0010, 64'h100, 64'h10, 64'd0, 5'd4, 5'b11010, 0);
    cycle();
    drive_id(1, 4, 2, 8, 64'h40, 64'h2, 64'd0, 2'b10, 4'b0000, 0, 5'b10000);
    #1;  check_ex();
    chk("pre_reset.stall", 64'(stall_req), 64'(FWD));
    #2;  rst_n = 1'b0;
    #1;
    chk("async_reset.valid", 64'(ex_valid), 64'd0);
    chk("async_reset.ctrl", 64'(ex_ctrl), 64'd0);
    chk("async_reset.stall", 64'(stall_req), 64'd0);
    chk("async_reset.rd", 64'(ex_rd), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
